reg16_we: RTL and testbench

- General-purpose 16-bit storage register with a write enable, used as a datapath register (e.g. program counter, instruction, or scratch register).
- Captures input I on the rising edge of CLK when Write is high.
- Holds its value when Write is low.
- Output O is the registered value, always visible combinationally.

---
 rtl/reg_pkg.sv | 15 +
 rtl/dff_en.sv | 20 ++
 rtl/reg16_we.sv | 46 ++++
 tb/tb_reg16_we.sv | 136 +++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the general-purpose datapath registers:
// default width, reset value, the word type and a parity helper.
package reg_pkg;

    localparam int REG_WIDTH = 16;
    localparam logic [REG_WIDTH-1:0] REG_RESET_VAL = 16'h0000;

    typedef logic [REG_WIDTH-1:0] word_t;

    // Even parity: XOR of all bits, so the word plus this bit has an even count of ones.
    function automatic logic even_par(input word_t v);
        return ^v;
    endfunction

endpackage

// File: rtl/dff_en.sv
// Single-bit D flip-flop with load enable and asynchronous active-low reset.
module dff_en #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg16_we.sv
// 16-bit write-enabled storage register built from per-bit enable flops.
// Define REG16_PARITY_EN to add a registered even-parity output O_PAR.
module reg16_we
    import reg_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = REG_RESET_VAL
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Write,
    input  logic [WIDTH-1:0] I,
`ifdef REG16_PARITY_EN
    output logic             O_PAR,
`endif
    output logic [WIDTH-1:0] O
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        dff_en #(
            .RST_VAL(RESET_VAL[b])
        ) u_bit (
            .clk  (CLK),
            .rst_n(RST_N),
            .en   (Write),
            .d    (I[b]),
            .q    (O[b])
        );
    end

`ifdef REG16_PARITY_EN
    // Parity is computed from I and captured on the same enable, so it tracks O exactly.
    dff_en #(
        .RST_VAL(even_par(RESET_VAL))
    ) u_par (
        .clk  (CLK),
        .rst_n(RST_N),
        .en   (Write),
        .d    (even_par(I)),
        .q    (O_PAR)
    );
`else
    // Without parity the register is just the data flops above.
`endif

endmodule

// File: tb/tb_reg16_we.sv
// Directed self-checking bench for reg16_we: expected values are queued when
// stimulus is driven and compared after the next rising edge.
module tb_reg16_we;
    import reg_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        Write;
    logic [15:0] I;
    logic [15:0] O;
`ifdef REG16_PARITY_EN
    logic        O_PAR;
`endif

    logic [15:0] exp_q[$];
    logic [15:0] model;
    int          n_cmp;
    int          n_err;

    reg16_we dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .Write(Write),
        .I    (I),
`ifdef REG16_PARITY_EN
        .O_PAR(O_PAR),
`endif
        .O    (O)
    );

    // clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // scoreboard compare: pops the oldest expected value
    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h but expected queue is empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic check_par(input string tag);
`ifdef REG16_PARITY_EN
        check(tag, {15'd0, O_PAR});
`else
        exp_q.delete();
`endif
    endtask

    // driver: change inputs on the falling edge, sample while CLK is high
    task automatic cycle(input logic wr, input logic [15:0] din, input string tag);
        @(negedge CLK);
        Write = wr;
        I     = din;
        if (RST_N && wr) model = din;
        exp_q.push_back(model);
        exp_q.push_back({15'd0, ^model});
        @(posedge CLK);
        #2;
        check(tag, O);
        check_par({tag, "_par"});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model = 16'h0000;
        RST_N = 1'b0;
        Write = 1'b1;
        I     = 16'hFFFF;

        // reset held: O stays at reset value despite Write=1, I=FFFF
        #1;
        exp_q.push_back(16'h0000);
        check("reset_initial", O);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #2;
            exp_q.push_back(16'h0000);
            check("reset_hold", O);
            exp_q.push_back(16'h0000);
            check_par("reset_hold_par");
        end

        // release reset away from the rising edge
        @(negedge CLK);
        RST_N = 1'b1;

        // sequential load 0..63
        for (int k = 0; k < 64; k++) cycle(1'b1, 16'(k), "seq_load");

        // hold at 63 while I moves
        for (int k = 0; k < 64; k++) cycle(1'b0, 16'(k), "hold");

        // extremes
        cycle(1'b1, 16'hFFFF, "load_ffff");
        cycle(1'b1, 16'h0000, "load_0000");
        cycle(1'b1, 16'hA5A5, "load_a5a5");
        cycle(1'b0, $urandom_range(0, 16'hFFFF), "hold_a5a5");
        cycle(1'b1, $urandom_range(0, 16'hFFFF), "load_random");

        // async reset mid-cycle
        cycle(1'b1, 16'h1234, "load_1234");
        #1;
        RST_N = 1'b0;
        model = 16'h0000;
        #1;
        exp_q.push_back(16'h0000);
        check("async_reset_now", O);
        RST_N = 1'b1;
        cycle(1'b0, 16'hFFFF, "after_reset_hold");
        cycle(1'b0, 16'h5555, "after_reset_hold2");
        cycle(1'b1, 16'h5A5A, "after_reset_load");

`ifdef REG16_PARITY_EN
        cycle(1'b1, 16'h0001, "par_load_0001");
        cycle(1'b1, 16'h0003, "par_load_0003");
        cycle(1'b0, 16'h0007, "par_hold");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
